// File: rtl/sp_det_pkg.sv
// Shared types and sizing helpers for the serial pattern detector.
package sp_det_pkg;

    localparam int unsigned WMin = 2;
    localparam int unsigned WMax = 16;

    typedef enum logic {
        StFill,
        StArmed
    } det_state_e;

    // Fill counter must be able to hold the value W itself.
    function automatic int unsigned fill_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky all-ones flag.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             sat_d, sat_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
        sat_d = sat_q | (cnt_d == CntMax);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = sat_q;

endmodule

// File: rtl/serial_pattern_detector.sv
// Programmable W-bit serial pattern detector with qualified input, overlap mode,
// soft clear with pattern reload and a saturating match counter.
module serial_pattern_detector
    import sp_det_pkg::*;
#(
    parameter int unsigned W     = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x,
    input  logic             x_valid,
    input  logic [W-1:0]     pattern,
    input  logic             overlap,
    input  logic             clear,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    if ((W < WMin) || (W > WMax)) begin : g_bad_w
        $error("serial_pattern_detector: W out of legal range");
    end

    localparam int unsigned   FW       = fill_width(W);
    localparam logic [FW-1:0] FillFull = FW'(W);
    localparam logic [FW-1:0] FillLast = FW'(W - 1);

    logic [W-1:0]  hist_d, hist_q;
    logic [W-1:0]  pat_d, pat_q;
    logic [FW-1:0] fill_d, fill_q;
    det_state_e    st_d, st_q;
    logic          z_d, z_q;
    logic [W-1:0]  nxt;
    logic          hit;

    always_comb begin
        nxt    = {hist_q[W-2:0], x};
        hit    = x_valid && ((st_q == StArmed) || (fill_q == FillLast)) && (nxt == pat_q);
        hist_d = hist_q;
        pat_d  = pat_q;
        fill_d = fill_q;
        st_d   = st_q;
        z_d    = 1'b0;
        if (x_valid) begin
            hist_d = nxt;
            z_d    = hit;
            if (hit && !overlap) begin
                fill_d = '0;
                st_d   = StFill;
            end else if (hit) begin
                fill_d = FillFull;
                st_d   = StArmed;
            end else begin
                fill_d = (fill_q == FillFull) ? FillFull : fill_q + 1'b1;
                st_d   = (fill_d == FillFull) ? StArmed : StFill;
            end
        end
    end

    // Clear behaves exactly like reset, including the pattern reload.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            hist_q <= '0;
            pat_q  <= pattern;
            fill_q <= '0;
            st_q   <= StFill;
            z_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            pat_q  <= pat_d;
            fill_q <= fill_d;
            st_q   <= st_d;
            z_q    <= z_d;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clear),
        .inc  (hit),
        .cnt  (match_cnt),
        .sat  (cnt_sat)
    );

    assign z = z_q;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Randomised and directed check of serial_pattern_detector against a queue-based model.
module tb_serial_pattern_detector;

    localparam int unsigned W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         x;
    logic         x_valid;
    logic [W-1:0] pattern;
    logic         overlap;
    logic         clear;
    logic         z_a, z_b;
    logic [7:0]   cnt_a;
    logic [1:0]   cnt_b;
    logic         sat_a, sat_b;

    always #5 clk = ~clk;

    serial_pattern_detector #(
        .W    (W),
        .CNT_W(8)
    ) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .x        (x),
        .x_valid  (x_valid),
        .pattern  (pattern),
        .overlap  (overlap),
        .clear    (clear),
        .z        (z_a),
        .match_cnt(cnt_a),
        .cnt_sat  (sat_a)
    );

    serial_pattern_detector #(
        .W    (W),
        .CNT_W(2)
    ) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .x        (x),
        .x_valid  (x_valid),
        .pattern  (pattern),
        .overlap  (overlap),
        .clear    (clear),
        .z        (z_b),
        .match_cnt(cnt_b),
        .cnt_sat  (sat_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: bits seen since the last reset/clear/non-overlap match.
    bit hist_m[$];
    int pat_m;
    int z_m;
    int cnt_am, cnt_bm;
    int sat_am, sat_bm;
    int zcount;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic xi, input logic vi, input logic clri, input logic rsti);
        int val;
        bit hit;
        x       = xi;
        x_valid = vi;
        clear   = clri;
        rst_n   = rsti;
        @(posedge clk);
        if (!rsti || clri) begin
            hist_m.delete();
            pat_m  = int'(pattern);
            z_m    = 0;
            cnt_am = 0;
            cnt_bm = 0;
            sat_am = 0;
            sat_bm = 0;
        end else if (vi) begin
            hist_m.push_back(xi);
            if (hist_m.size() > W) void'(hist_m.pop_front());
            val = 0;
            foreach (hist_m[i]) val = val * 2 + int'(hist_m[i]);
            hit = (hist_m.size() == W) && (val == pat_m);
            z_m = int'(hit);
            if (hit) begin
                cnt_am = (cnt_am < 255) ? cnt_am + 1 : 255;
                cnt_bm = (cnt_bm < 3) ? cnt_bm + 1 : 3;
                if (cnt_am == 255) sat_am = 1;
                if (cnt_bm == 3) sat_bm = 1;
                if (!overlap) hist_m.delete();
            end
        end else begin
            z_m = 0;
        end
        #1;
        if (z_a === 1'b1) zcount++;
        check("z_a", 32'(z_a), 32'(z_m));
        check("cnt_a", 32'(cnt_a), 32'(cnt_am));
        check("sat_a", 32'(sat_a), 32'(sat_am));
        check("z_b", 32'(z_b), 32'(z_m));
        check("cnt_b", 32'(cnt_b), 32'(cnt_bm));
        check("sat_b", 32'(sat_b), 32'(sat_bm));
    endtask

    task automatic feed(input logic xi);
        step(xi, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic gap();
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        x       = 1'b0;
        x_valid = 1'b0;
        clear   = 1'b0;
        rst_n   = 1'b0;
        overlap = 1'b1;
        pattern = 3'b101;
        @(negedge clk);

        // Overlapping 1,0,1,0,1 -> two pulses
        do_reset();
        check("rst_z", 32'(z_a), 32'd0);
        check("rst_cnt", 32'(cnt_a), 32'd0);
        zcount = 0;
        feed(1); feed(0); feed(1); feed(0); feed(1);
        check("ovl_pulses", 32'(zcount), 32'd2);
        check("ovl_cnt", 32'(cnt_a), 32'd2);
        check("ovl_sat", 32'(sat_a), 32'd0);

        // Non-overlapping: one pulse, then 1,0,1 gives another
        overlap = 1'b0;
        do_reset();
        zcount = 0;
        feed(1); feed(0); feed(1); feed(0); feed(1);
        check("novl_pulses", 32'(zcount), 32'd1);
        feed(1); feed(0); feed(1);
        check("novl_z8", 32'(z_a), 32'd1);
        check("novl_cnt", 32'(cnt_a), 32'd2);

        // Gaps between valid bits never break a sequence
        overlap = 1'b1;
        do_reset();
        zcount = 0;
        feed(1); gap(); gap(); feed(0); gap(); gap(); feed(1);
        check("gap_z", 32'(z_a), 32'd1);
        gap(); gap();
        check("gap_pulses", 32'(zcount), 32'd1);

        // Clear reloads the pattern and discards history
        do_reset();
        feed(1); feed(0);
        pattern = 3'b011;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        pattern = 3'b101;
        zcount = 0;
        feed(1);
        check("clr_nopulse", 32'(z_a), 32'd0);
        feed(0); feed(1); feed(1);
        check("clr_reload_z", 32'(z_a), 32'd1);
        check("clr_cnt", 32'(cnt_a), 32'd1);

        // Saturation of the narrow counter
        pattern = 3'b111;
        do_reset();
        for (int i = 0; i < 6; i++) feed(1);
        check("sat_cnt_b", 32'(cnt_b), 32'd3);
        check("sat_flag_b", 32'(sat_b), 32'd1);
        check("sat_cnt_a", 32'(cnt_a), 32'd4);
        feed(0); gap();
        check("sat_sticky", 32'(sat_b), 32'd1);

        // Mid-stream reset
        pattern = 3'b101;
        do_reset();
        feed(1); feed(0);
        do_reset();
        check("mrst_z", 32'(z_a), 32'd0);
        check("mrst_cnt", 32'(cnt_a), 32'd0);
        check("mrst_sat", 32'(sat_a), 32'd0);
        feed(1);
        check("mrst_nopulse", 32'(z_a), 32'd0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) overlap = 1'($urandom);
            pattern = 3'($urandom);
            step(1'($urandom), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) >= 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_pattern_detector.md
Name: serial_pattern_detector

Overview:
- Parametrised serial-bit sequence detector; generalises the fixed 3-flop serial detector into a W-bit programmable pattern matcher.
- Adds a qualified input strobe, an overlapping/non-overlapping mode, synchronous clear with pattern reload, and a saturating match counter.
- Sits on a single-bit serial stream; z is a registered one-cycle match pulse for downstream control logic.

Parameters:
- W, 3, pattern length in bits; legal range 2..16.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- x  input  1  serial data bit; sampled only when x_valid=1.
- x_valid  input  1  qualifies x for the current cycle.
- pattern  input  W  target pattern; pattern[W-1] is the first bit received, pattern[0] the last; captured into pat_q, not compared live.
- overlap  input  1  1 = overlapping matches allowed; 0 = history discarded after each match. Read every cycle.
- clear  input  1  synchronous soft clear plus pattern reload.
- z  output  1  registered match pulse, one cycle wide.
- match_cnt  output  CNT_W  number of matches since reset/clear; saturates.
- cnt_sat  output  1  sticky flag; set when match_cnt reaches all-ones.

Behaviour:
- Internal state:
  - hist[W-1:0]: shift history.
  - fill: counter of width clog2(W+1), saturating at W.
  - pat_q[W-1:0]: captured pattern.
  - st in {FILL, ARMED}.
- Reset (rst_n=0 at posedge): hist=0, fill=0, st=FILL, pat_q<=pattern, z=0, match_cnt=0, cnt_sat=0. Reset overrides all other inputs.
- clear=1 with rst_n=1: identical effect to reset, including the pattern reload. clear has priority over x_valid in the same cycle.
- x_valid=0, no clear: hist, fill, st, match_cnt and cnt_sat hold; z<=0. Gaps never break a sequence.
- x_valid=1, no clear:
  - nxt = {hist[W-2:0], x}; hist<=nxt.
  - hit = (st==ARMED or fill==W-1) and (nxt==pat_q).
  - z<=hit. Latency: z is high in the cycle after the posedge that sampled the completing bit.
  - On hit:
    - match_cnt increments unless already all-ones.
    - cnt_sat<=1 when match_cnt reaches all-ones; cnt_sat stays set until reset or clear.
  - On hit with overlap=0: fill<=0, st<=FILL. The next match needs W fresh bits.
  - On hit with overlap=1: fill<=W, st<=ARMED.
  - No hit: fill<=min(fill+1,W); st<=ARMED once fill reaches W, else FILL.
- FSM transitions:
  - FILL->ARMED on the W-th valid bit.
  - ARMED->FILL only on a hit with overlap=0, or on clear/reset.
- Changing the pattern input while running has no effect until the next clear or reset.
- Toggling overlap mid-stream applies to the next hit only.
- A match is never reported until W valid bits have been received since the last reset, clear or non-overlap match.

Decomposition:
- Shared package sp_det_pkg:
  - state enum type (FILL, ARMED).
  - clog2-based fill width constant/function.
  - Legal W range constants, checked by an elaboration-time assertion.
- One natural sub-module: sat_counter (CNT_W wide, inc, sync clear, count out, sat flag). It is reusable by other blocks.
- Shift/compare/FSM logic stays in the top module.

Test Plan:
- W=3, pattern=101, overlap=1, contiguous valid bits 1,0,1,0,1 -> z pulses after bit 3 and after bit 5; match_cnt=2; cnt_sat=0.
- Same stream with overlap=0 -> single z pulse after bit 3; match_cnt=1. Then feed 1,0,1 -> pulse after bit 8 of the stream; match_cnt=2.
- W=3, pattern=101, bits 1,0,1 with x_valid=0 gaps of 2 cycles between bits -> exactly one z pulse, one cycle after the posedge sampling the final 1; z=0 throughout the gaps.
- Feed 1,0, then clear=1 with pattern=011, then 1 -> no pulse. Then feed 0,1,1 -> pulse after the final 1, proving the reload; match_cnt=1.
- CNT_W=2, pattern=111, overlap=1, six 1s -> z pulses on bits 3,4,5,6; match_cnt=1,2,3,3; cnt_sat rises with the third match and stays 1.
- Mid-stream rst_n=0 for one cycle after bits 1,0 (pattern=101), then 1 -> no pulse; all outputs read 0 the cycle after reset.
